// File: rtl/fpu_issue_rob.sv
// FP issue/reorder hub: dispatches tagged ops to multi-cycle units, collects
// out-of-order completions and retires results to writeback in issue order.
module fpu_issue_rob #(
    parameter int NUM_UNITS = 4,
    parameter int DEPTH     = 4,
    parameter int DATA_W    = 64,
    parameter int FLAG_W    = 5,
    parameter int TAG_W     = 5,
    localparam int UW       = $clog2(NUM_UNITS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic [UW-1:0]               req_unit_i,
    input  logic [TAG_W-1:0]            req_tag_i,
    output logic [NUM_UNITS-1:0]        unit_issue_valid_o,
    input  logic [NUM_UNITS-1:0]        unit_issue_ready_i,
    input  logic [NUM_UNITS-1:0]        unit_done_valid_i,
    input  logic [NUM_UNITS*DATA_W-1:0] unit_done_result_i,
    input  logic [NUM_UNITS*FLAG_W-1:0] unit_done_flags_i,
    output logic                        wb_valid_o,
    input  logic                        wb_ready_i,
    output logic [DATA_W-1:0]           wb_result_o,
    output logic [FLAG_W-1:0]           wb_flags_o,
    output logic [TAG_W-1:0]            wb_tag_o,
    output logic                        busy_o,
    output logic                        err_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {FREE, ISSUED, DONE} entry_state_t;

    entry_state_t        state_q  [DEPTH];
    entry_state_t        state_d  [DEPTH];
    logic [UW-1:0]       unit_q   [DEPTH];
    logic [UW-1:0]       unit_d   [DEPTH];
    logic [TAG_W-1:0]    tag_q    [DEPTH];
    logic [TAG_W-1:0]    tag_d    [DEPTH];
    logic [DATA_W-1:0]   result_q [DEPTH];
    logic [DATA_W-1:0]   result_d [DEPTH];
    logic [FLAG_W-1:0]   flags_q  [DEPTH];
    logic [FLAG_W-1:0]   flags_d  [DEPTH];

    logic [PW-1:0]       head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]       count_q, count_d;
    logic                err_q, err_d;

    logic                full, sel_ready, accept, pop;
    logic [NUM_UNITS-1:0] match_hit;
    logic [PW-1:0]       match_idx [NUM_UNITS];

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PW-1:0] slot_at(input logic [PW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= 32'(DEPTH)) s = s - 32'(DEPTH);
        return PW'(s);
    endfunction

    assign full = (count_q == CW'(DEPTH));

    // Decoding against each legal index leaves out-of-range unit selects unready.
    always_comb begin
        sel_ready          = 1'b0;
        unit_issue_valid_o = '0;
        for (int unsigned u = 0; u < NUM_UNITS; u++) begin
            if (req_unit_i == UW'(u)) begin
                sel_ready             = unit_issue_ready_i[u];
                unit_issue_valid_o[u] = req_valid_i & ~full & ~clear & rst_n;
            end
        end
    end

    assign req_ready_o = sel_ready & ~full & ~clear & rst_n;
    assign accept      = req_valid_i & req_ready_o;
    assign wb_valid_o  = (state_q[head_q] == DONE);
    assign pop         = wb_valid_o & wb_ready_i & ~clear;

    // Oldest ISSUED entry per unit, scanning from head; uses registered state only.
    always_comb begin
        for (int unsigned u = 0; u < NUM_UNITS; u++) begin
            match_hit[u] = 1'b0;
            match_idx[u] = '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (!match_hit[u] && state_q[slot_at(head_q, k)] == ISSUED
                    && unit_q[slot_at(head_q, k)] == UW'(u)) begin
                    match_hit[u] = 1'b1;
                    match_idx[u] = slot_at(head_q, k);
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        unit_d   = unit_q;
        tag_d    = tag_q;
        result_d = result_q;
        flags_d  = flags_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        err_d    = err_q;
        if (clear) begin
            for (int unsigned i = 0; i < DEPTH; i++) state_d[i] = FREE;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            for (int unsigned u = 0; u < NUM_UNITS; u++) begin
                if (unit_done_valid_i[u]) begin
                    if (match_hit[u]) begin
                        state_d[match_idx[u]]  = DONE;
                        result_d[match_idx[u]] = unit_done_result_i[u*DATA_W +: DATA_W];
                        flags_d[match_idx[u]]  = unit_done_flags_i[u*FLAG_W +: FLAG_W];
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            // Tail slot is FREE and head slot is DONE, so these never touch a matched entry.
            if (accept) begin
                state_d[tail_q] = ISSUED;
                unit_d[tail_q]  = req_unit_i;
                tag_d[tail_q]   = req_tag_i;
                tail_d          = next_ptr(tail_q);
            end
            if (pop) begin
                state_d[head_q] = FREE;
                head_d          = next_ptr(head_q);
            end
            case ({accept, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                state_q[i]  <= FREE;
                unit_q[i]   <= '0;
                tag_q[i]    <= '0;
                result_q[i] <= '0;
                flags_q[i]  <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            unit_q   <= unit_d;
            tag_q    <= tag_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    assign wb_result_o = result_q[head_q];
    assign wb_flags_o  = flags_q[head_q];
    assign wb_tag_o    = tag_q[head_q];
    assign busy_o      = (count_q != '0);
    assign err_o       = err_q;

endmodule

// File: tb/tb_fpu_issue_rob.sv
// Directed bench for fpu_issue_rob: per-cycle vector table plus hand-written
// sequences for flush, unit back-pressure, stray completions and async reset.
module tb_fpu_issue_rob;

    localparam int NU = 4;
    localparam int DP = 4;
    localparam int DW = 64;
    localparam int FW = 5;
    localparam int TW = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clear = 1'b0;
    logic              req_valid_i = 1'b0;
    logic              req_ready_o;
    logic [1:0]        req_unit_i = '0;
    logic [TW-1:0]     req_tag_i = '0;
    logic [NU-1:0]     unit_issue_valid_o;
    logic [NU-1:0]     unit_issue_ready_i = '1;
    logic [NU-1:0]     unit_done_valid_i = '0;
    logic [NU*DW-1:0]  unit_done_result_i = '0;
    logic [NU*FW-1:0]  unit_done_flags_i = '0;
    logic              wb_valid_o;
    logic              wb_ready_i = 1'b0;
    logic [DW-1:0]     wb_result_o;
    logic [FW-1:0]     wb_flags_o;
    logic [TW-1:0]     wb_tag_o;
    logic              busy_o;
    logic              err_o;

    always #5 clk = ~clk;

    fpu_issue_rob #(.NUM_UNITS(NU), .DEPTH(DP), .DATA_W(DW), .FLAG_W(FW), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_unit_i(req_unit_i), .req_tag_i(req_tag_i),
        .unit_issue_valid_o(unit_issue_valid_o), .unit_issue_ready_i(unit_issue_ready_i),
        .unit_done_valid_i(unit_done_valid_i), .unit_done_result_i(unit_done_result_i),
        .unit_done_flags_i(unit_done_flags_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_result_o(wb_result_o),
        .wb_flags_o(wb_flags_o), .wb_tag_o(wb_tag_o), .busy_o(busy_o), .err_o(err_o)
    );

    typedef struct {
        logic          rv;
        logic [1:0]    ru;
        logic [TW-1:0] rt;
        logic [NU-1:0] dv;
        logic [DW-1:0] dres;   // unit u reports dres + u
        logic [FW-1:0] dfl;
        logic          wr;
        logic          clr;
        logic          e_rr;
        logic          e_wv;
        logic [TW-1:0] e_tag;
        logic [DW-1:0] e_res;
        logic [FW-1:0] e_fl;
        logic          e_busy;
        logic          e_err;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input bit rv, input int ru, input int rt, input logic [NU-1:0] dv,
                                input logic [DW-1:0] dres, input logic [FW-1:0] dfl, input bit wr,
                                input bit clr, input bit e_rr, input bit e_wv, input int e_tag,
                                input logic [DW-1:0] e_res, input logic [FW-1:0] e_fl,
                                input bit e_busy, input bit e_err);
        vec_t v;
        v.rv = rv; v.ru = 2'(ru); v.rt = TW'(rt); v.dv = dv; v.dres = dres; v.dfl = dfl;
        v.wr = wr; v.clr = clr; v.e_rr = e_rr; v.e_wv = e_wv; v.e_tag = TW'(e_tag);
        v.e_res = e_res; v.e_fl = e_fl; v.e_busy = e_busy; v.e_err = e_err;
        return v;
    endfunction

    task automatic step(input vec_t t, input string nm);
        logic [NU-1:0] e_iv;
        @(negedge clk);
        req_valid_i       = t.rv;
        req_unit_i        = t.ru;
        req_tag_i         = t.rt;
        wb_ready_i        = t.wr;
        clear             = t.clr;
        unit_done_valid_i = t.dv;
        for (int u = 0; u < NU; u++) begin
            unit_done_result_i[u*DW +: DW] = t.dres + 64'(u);
            unit_done_flags_i[u*FW +: FW]  = t.dfl;
        end
        #1;
        e_iv = (t.rv && t.e_rr) ? NU'(1) << t.ru : '0;
        chk({nm, ".req_ready"}, 64'(req_ready_o), 64'(t.e_rr));
        chk({nm, ".issue_valid"}, 64'(unit_issue_valid_o), 64'(e_iv));
        chk({nm, ".wb_valid"}, 64'(wb_valid_o), 64'(t.e_wv));
        chk({nm, ".busy"}, 64'(busy_o), 64'(t.e_busy));
        chk({nm, ".err"}, 64'(err_o), 64'(t.e_err));
        if (t.e_wv) begin
            chk({nm, ".wb_tag"}, 64'(wb_tag_o), 64'(t.e_tag));
            chk({nm, ".wb_result"}, wb_result_o, t.e_res);
            chk({nm, ".wb_flags"}, 64'(wb_flags_o), 64'(t.e_fl));
        end
    endtask

    vec_t tbl[$];

    initial begin
        // in-order scenarios: single op, out-of-order pair, fill/wrap through 8 ops
        tbl.push_back(mk(0,0,0, 4'b0000, 64'h0, 0, 0,0,  1,0,0, 64'h0, 0, 0,0));
        tbl.push_back(mk(1,1,3, 4'b0000, 64'h0, 0, 0,0,  1,0,0, 64'h0, 0, 0,0));
        tbl.push_back(mk(0,0,0, 4'b0000, 64'h0, 0, 0,0,  1,0,0, 64'h0, 0, 1,0));
        tbl.push_back(mk(0,0,0, 4'b0010, 64'h3FF0_0000_0000_0000 - 64'd1, 0, 0,0,  1,0,0, 64'h0, 0, 1,0));
        tbl.push_back(mk(0,0,0, 4'b0000, 64'h0, 0, 1,0,  1,1,3, 64'h3FF0_0000_0000_0000, 0, 1,0));
        tbl.push_back(mk(0,0,0, 4'b0000, 64'h0, 0, 0,0,  1,0,0, 64'h0, 0, 0,0));
        tbl.push_back(mk(1,0,1, 4'b0000, 64'h0, 0, 0,0,  1,0,0, 64'h0, 0, 0,0));
        tbl.push_back(mk(1,2,2, 4'b0000, 64'h0, 0, 0,0,  1,0,0, 64'h0, 0, 1,0));
        tbl.push_back(mk(0,0,0, 4'b0100, 64'h4000_0000_0000_0000 - 64'd2, 0, 1,0,  1,0,0, 64'h0, 0, 1,0));
        tbl.push_back(mk(0,0,0, 4'b0000, 64'h0, 0, 1,0,  1,0,0, 64'h0, 0, 1,0));
        tbl.push_back(mk(0,0,0, 4'b0001, 64'h1111, 0, 1,0,  1,0,0, 64'h0, 0, 1,0));
        tbl.push_back(mk(0,0,0, 4'b0000, 64'h0, 0, 1,0,  1,1,1, 64'h1111, 0, 1,0));
        tbl.push_back(mk(0,0,0, 4'b0000, 64'h0, 0, 1,0,  1,1,2, 64'h4000_0000_0000_0000, 0, 1,0));
        tbl.push_back(mk(0,0,0, 4'b0000, 64'h0, 0, 0,0,  1,0,0, 64'h0, 0, 0,0));
        tbl.push_back(mk(1,0,10, 4'b0000, 64'h0, 0, 0,0,  1,0,0, 64'h0, 0, 0,0));
        tbl.push_back(mk(1,1,11, 4'b0000, 64'h0, 0, 0,0,  1,0,0, 64'h0, 0, 1,0));
        tbl.push_back(mk(1,2,12, 4'b0000, 64'h0, 0, 0,0,  1,0,0, 64'h0, 0, 1,0));
        tbl.push_back(mk(1,3,13, 4'b0000, 64'h0, 0, 0,0,  1,0,0, 64'h0, 0, 1,0));
        tbl.push_back(mk(1,0,14, 4'b0000, 64'h0, 0, 0,0,  0,0,0, 64'h0, 0, 1,0));
        tbl.push_back(mk(1,0,14, 4'b1111, 64'hA0, 0, 0,0,  0,0,0, 64'h0, 0, 1,0));
        tbl.push_back(mk(1,0,14, 4'b0000, 64'h0, 0, 1,0,  0,1,10, 64'hA0, 0, 1,0));
        tbl.push_back(mk(1,0,14, 4'b0000, 64'h0, 0, 0,0,  1,1,11, 64'hA1, 0, 1,0));
        tbl.push_back(mk(1,1,15, 4'b0000, 64'h0, 0, 0,0,  0,1,11, 64'hA1, 0, 1,0));
        tbl.push_back(mk(1,1,15, 4'b0000, 64'h0, 0, 1,0,  0,1,11, 64'hA1, 0, 1,0));
        tbl.push_back(mk(1,1,15, 4'b0000, 64'h0, 0, 1,0,  1,1,12, 64'hA2, 0, 1,0));
        tbl.push_back(mk(1,2,16, 4'b0000, 64'h0, 0, 1,0,  1,1,13, 64'hA3, 0, 1,0));
        tbl.push_back(mk(1,3,17, 4'b0111, 64'hB0, 0, 1,0,  1,0,0, 64'h0, 0, 1,0));
        tbl.push_back(mk(0,0,0, 4'b1000, 64'hC0, 0, 1,0,  0,1,14, 64'hB0, 0, 1,0));
        tbl.push_back(mk(0,0,0, 4'b0000, 64'h0, 0, 1,0,  1,1,15, 64'hB1, 0, 1,0));
        tbl.push_back(mk(0,0,0, 4'b0000, 64'h0, 0, 1,0,  1,1,16, 64'hB2, 0, 1,0));
        tbl.push_back(mk(0,0,0, 4'b0000, 64'h0, 0, 1,0,  1,1,17, 64'hC3, 0, 1,0));
        tbl.push_back(mk(0,0,0, 4'b0000, 64'h0, 0, 0,0,  1,0,0, 64'h0, 0, 0,0));

        // reset state, with a request pending on unit 2
        req_valid_i = 1'b1;
        req_unit_i  = 2'd2;
        #12;
        chk("rst.wb_valid", 64'(wb_valid_o), 64'd0);
        chk("rst.wb_result", wb_result_o, 64'd0);
        chk("rst.wb_flags", 64'(wb_flags_o), 64'd0);
        chk("rst.wb_tag", 64'(wb_tag_o), 64'd0);
        chk("rst.busy", 64'(busy_o), 64'd0);
        chk("rst.err", 64'(err_o), 64'd0);
        chk("rst.issue_valid", 64'(unit_issue_valid_o), 64'd0);
        @(negedge clk);
        req_valid_i = 1'b0;
        rst_n       = 1'b1;

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

        // same-unit pair keeps order; outputs held during stall
        step(mk(1,1,4, 4'b0000, 64'h0, 0, 0,0,  1,0,0, 64'h0, 0, 0,0), "su.a");
        step(mk(1,1,5, 4'b0000, 64'h0, 0, 0,0,  1,0,0, 64'h0, 0, 1,0), "su.b");
        step(mk(0,0,0, 4'b0010, 64'h100, 5'h01, 0,0,  1,0,0, 64'h0, 0, 1,0), "su.c");
        step(mk(0,0,0, 4'b0010, 64'h200, 5'h10, 0,0,  1,1,4, 64'h101, 5'h01, 1,0), "su.d");
        step(mk(0,0,0, 4'b0000, 64'h0, 0, 0,0,  1,1,4, 64'h101, 5'h01, 1,0), "su.e");
        step(mk(0,0,0, 4'b0000, 64'h0, 0, 1,0,  1,1,4, 64'h101, 5'h01, 1,0), "su.f");
        step(mk(0,0,0, 4'b0000, 64'h0, 0, 0,0,  1,1,5, 64'h201, 5'h10, 1,0), "su.g");
        step(mk(0,0,0, 4'b0000, 64'h0, 0, 1,0,  1,1,5, 64'h201, 5'h10, 1,0), "su.h");
        step(mk(0,0,0, 4'b0000, 64'h0, 0, 0,0,  1,0,0, 64'h0, 0, 0,0), "su.i");

        // flush with a stray completion in the clear cycle
        step(mk(1,0,6, 4'b0000, 64'h0, 0, 0,0,  1,0,0, 64'h0, 0, 0,0), "cl.a");
        step(mk(1,1,7, 4'b0000, 64'h0, 0, 0,0,  1,0,0, 64'h0, 0, 1,0), "cl.b");
        step(mk(1,2,8, 4'b0000, 64'h0, 0, 0,0,  1,0,0, 64'h0, 0, 1,0), "cl.c");
        step(mk(1,3,9, 4'b1000, 64'h0, 0, 1,1,  0,0,0, 64'h0, 0, 1,0), "cl.d");
        step(mk(1,3,9, 4'b0000, 64'h0, 0, 0,0,  1,0,0, 64'h0, 0, 0,0), "cl.e");
        step(mk(0,0,0, 4'b1000, 64'h300, 0, 0,0,  1,0,0, 64'h0, 0, 1,0), "cl.f");
        step(mk(0,0,0, 4'b0000, 64'h0, 0, 1,0,  1,1,9, 64'h303, 0, 1,0), "cl.g");
        step(mk(0,0,0, 4'b0000, 64'h0, 0, 0,0,  1,0,0, 64'h0, 0, 0,0), "cl.h");

        // target unit not ready: strobe still raised, request not accepted
        @(negedge clk);
        unit_issue_ready_i = 4'b1011;
        req_valid_i        = 1'b1;
        req_unit_i         = 2'd2;
        req_tag_i          = 5'd30;
        #1;
        chk("nr.req_ready", 64'(req_ready_o), 64'd0);
        chk("nr.issue_valid", 64'(unit_issue_valid_o), 64'h4);
        @(negedge clk);
        req_valid_i        = 1'b0;
        unit_issue_ready_i = '1;
        #1;
        chk("nr.busy", 64'(busy_o), 64'd0);

        // stray completion sets sticky err; async reset mid-operation
        step(mk(0,0,0, 4'b1000, 64'h0, 0, 0,0,  1,0,0, 64'h0, 0, 0,0), "er.a");
        step(mk(0,0,0, 4'b0000, 64'h0, 0, 0,0,  1,0,0, 64'h0, 0, 0,1), "er.b");
        step(mk(1,0,20, 4'b0000, 64'h0, 0, 0,0,  1,0,0, 64'h0, 0, 0,1), "er.c");
        step(mk(0,0,0, 4'b0001, 64'h500, 5'h03, 0,0,  1,0,0, 64'h0, 0, 1,1), "er.d");
        step(mk(1,2,21, 4'b0000, 64'h0, 0, 0,0,  1,1,20, 64'h500, 5'h03, 1,1), "er.e");
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar.wb_valid", 64'(wb_valid_o), 64'd0);
        chk("ar.wb_result", wb_result_o, 64'd0);
        chk("ar.wb_flags", 64'(wb_flags_o), 64'd0);
        chk("ar.wb_tag", 64'(wb_tag_o), 64'd0);
        chk("ar.busy", 64'(busy_o), 64'd0);
        chk("ar.err", 64'(err_o), 64'd0);
        chk("ar.issue_valid", 64'(unit_issue_valid_o), 64'd0);
        chk("ar.req_ready", 64'(req_ready_o), 64'd0);
        @(negedge clk);
        req_valid_i = 1'b0;
        rst_n       = 1'b1;
        step(mk(0,0,0, 4'b0000, 64'h0, 0, 0,0,  1,0,0, 64'h0, 0, 0,0), "ar.idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
